mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared 8-lane, 8-bit output multiplexer.
- Eight requesters present byte streams on packed lanes with a valid/ready handshake per lane.
- The block grants one lane at a time, drives the mux select, and registers the selected byte into a single valid/ready output channel.
- Optional packet locking holds the grant on one lane until that lane's last beat.

---
 rtl/mux8_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 8-lane byte multiplexer.
// One lane is granted per beat. The selected byte is registered into a
// single valid/ready output stage. With LOCK_EN set, a multi-beat packet
// keeps the grant on its lane until the beat that carries req_last.
module mux8_rr_arbiter #(
  parameter int NREQ    = 8,
  parameter int DW      = 8,
  parameter bit LOCK_EN = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NREQ-1:0]     req_valid_i,
  input  logic [NREQ*DW-1:0]  req_data_i,
  input  logic [NREQ-1:0]     req_last_i,
  output logic [NREQ-1:0]     req_ready_o,
  output logic                out_valid_o,
  output logic [DW-1:0]       out_data_o,
  output logic                out_last_o,
  input  logic                out_ready_i,
  output logic [2:0]          sel_o,
  output logic                locked_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      lk_q, lk_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      sel_q, sel_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [DW-1:0]   out_data_q, out_data_d;

  logic [2:0]      win;
  logic [2:0]      idx;
  logic            has_win;
  logic            load_en;
  logic            accept;

  // The output register can take a new beat when it is empty or draining.
  assign load_en = !out_valid_q || out_ready_i;
  assign accept  = load_en && has_win;

  // Winner selection: the locked lane while locked, otherwise the first valid
  // lane at or after ptr (descending scan so the nearest lane is kept last).
  always_comb begin
    win     = '0;
    idx     = '0;
    has_win = 1'b0;
    if (state_q == LOCKED) begin
      win     = lk_q;
      has_win = req_valid_i[lk_q];
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx = ptr_q + 3'(k);
        if (req_valid_i[idx]) begin
          win     = idx;
          has_win = 1'b1;
        end
      end
    end
  end

  // Ready goes only to the winning lane, and only in a cycle it is accepted.
  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[win] = 1'b1;
    end
  end

  // Output stage and pointer next values; everything holds while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = has_win;
      if (has_win) begin
        out_data_d = req_data_i[DW*win +: DW];
        out_last_d = req_last_i[win];
        sel_d      = win;
        ptr_d      = win + 3'd1;
      end
    end
  end

  // Packet-lock state machine next state; a lane that starts a packet without
  // last is held until its own last beat is accepted.
  always_comb begin
    state_d = state_q;
    lk_d    = lk_q;
    if (LOCK_EN && accept) begin
      case (state_q)
        IDLE: begin
          if (!req_last_i[win]) begin
            state_d = LOCKED;
            lk_d    = win;
          end
        end
        LOCKED: begin
          if (req_last_i[win]) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and lock-lane registers; reset drops any lock in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lk_q    <= '0;
    end else begin
      state_q <= state_d;
      lk_q    <= lk_d;
    end
  end

  // Output register, select and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      sel_q       <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign sel_o       = sel_q;
  assign locked_o    = (state_q == LOCKED);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter. Expected output beats are queued when
// an accept is expected and retired by a monitor on each output handshake.
module tb_mux8_rr_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic [7:0]  req_valid_i;
  logic [63:0] req_data_i;
  logic [7:0]  req_last_i;
  logic [7:0]  req_ready_o;
  logic        out_valid_o;
  logic [7:0]  out_data_o;
  logic        out_last_o;
  logic        out_ready_i;
  logic [2:0]  sel_o;
  logic        locked_o;

  int errors = 0;
  int checks = 0;

  // {data, last, sel}
  logic [11:0] expQ[$];

  mux8_rr_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_ready_i (out_ready_i),
    .sel_o       (sel_o),
    .locked_o    (locked_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] valid, input logic [7:0] last, input logic ordy);
    req_valid_i = valid;
    req_last_i  = last;
    out_ready_i = ordy;
  endtask

  task automatic setLane(input int lane, input logic [7:0] d);
    req_data_i[8*lane +: 8] = d;
  endtask

  task automatic expectBeat(input logic [7:0] d, input logic l, input logic [2:0] s);
    expQ.push_back({d, l, s});
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard: each output handshake retires the oldest expected beat.
  always @(negedge clk_i) begin
    logic [11:0] e;
    if (!rst_i && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
      checks++;
      assert (expQ.size() != 0) else begin
        errors++;
        $error("[TB] FAIL sb_unexpected: observed data %0h sel %0d expected no beat", out_data_o, sel_o);
      end
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("sb_data", 32'(out_data_o), 32'(e[11:4]));
        checkOutput("sb_last", 32'(out_last_o), 32'(e[3]));
        checkOutput("sb_sel",  32'(sel_o),      32'(e[2:0]));
      end
    end
  end

  initial begin
    rst_i       = 1'b1;
    req_data_i  = '0;
    applyStimulus(8'h00, 8'h00, 1'b1);

    // Reset with no requests
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("rst_valid",  32'(out_valid_o), 32'd0);
      checkOutput("rst_data",   32'(out_data_o),  32'd0);
      checkOutput("rst_sel",    32'(sel_o),       32'd0);
      checkOutput("rst_ready",  32'(req_ready_o), 32'd0);
      checkOutput("rst_locked", 32'(locked_o),    32'd0);
    end
    nextCycle();
    rst_i = 1'b0;

    // Round-robin fairness: every lane valid, single-beat packets
    for (int i = 0; i < 8; i++) setLane(i, 8'h10 + 8'(i));
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 9; i++) begin
      expectBeat(8'h10 + 8'(i % 8), 1'b1, 3'(i % 8));
      @(negedge clk_i);
      checkOutput("rr_ready", 32'(req_ready_o), 32'(8'h01 << (i % 8)));
      nextCycle();
    end

    // Wrap and skip: grant lane 5 so ptr becomes 6, then lanes 2 and 7
    applyStimulus(8'h20, 8'hFF, 1'b1);
    expectBeat(8'h15, 1'b1, 3'd5);
    @(negedge clk_i);
    checkOutput("wrap_ready5", 32'(req_ready_o), 32'h20);
    nextCycle();
    applyStimulus(8'h84, 8'hFF, 1'b1);
    expectBeat(8'h17, 1'b1, 3'd7);
    @(negedge clk_i);
    checkOutput("wrap_ready7", 32'(req_ready_o), 32'h80);
    nextCycle();
    expectBeat(8'h12, 1'b1, 3'd2);
    @(negedge clk_i);
    checkOutput("wrap_ready2", 32'(req_ready_o), 32'h04);
    nextCycle();

    // Backpressure: lane 3 beat held while out_ready is low
    setLane(3, 8'hA5);
    applyStimulus(8'h08, 8'hFF, 1'b1);
    expectBeat(8'hA5, 1'b1, 3'd3);
    @(negedge clk_i);
    checkOutput("bp_ready_first", 32'(req_ready_o), 32'h08);
    nextCycle();
    setLane(3, 8'h5A);
    applyStimulus(8'h08, 8'hFF, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      checkOutput("bp_valid", 32'(out_valid_o), 32'd1);
      checkOutput("bp_data",  32'(out_data_o),  32'hA5);
      checkOutput("bp_ready", 32'(req_ready_o), 32'd0);
      nextCycle();
    end
    applyStimulus(8'h08, 8'hFF, 1'b1);
    expectBeat(8'h5A, 1'b1, 3'd3);
    @(negedge clk_i);
    checkOutput("bp_ready_release", 32'(req_ready_o), 32'h08);
    nextCycle();
    applyStimulus(8'h00, 8'hFF, 1'b1);
    nextCycle();

    // Packet lock: lane 1 sends three beats with a gap, lane 4 waits
    setLane(1, 8'hB1);
    setLane(4, 8'hC4);
    applyStimulus(8'h02, 8'hFD, 1'b1);
    expectBeat(8'hB1, 1'b0, 3'd1);
    @(negedge clk_i);
    checkOutput("lock_ready_b1", 32'(req_ready_o), 32'h02);
    nextCycle();
    applyStimulus(8'h10, 8'hFD, 1'b1);
    @(negedge clk_i);
    checkOutput("lock_locked_gap", 32'(locked_o),    32'd1);
    checkOutput("lock_ready_gap",  32'(req_ready_o), 32'd0);
    nextCycle();
    setLane(1, 8'hB2);
    applyStimulus(8'h12, 8'hFD, 1'b1);
    expectBeat(8'hB2, 1'b0, 3'd1);
    @(negedge clk_i);
    checkOutput("lock_locked_b2", 32'(locked_o),    32'd1);
    checkOutput("lock_ready_b2",  32'(req_ready_o), 32'h02);
    nextCycle();
    setLane(1, 8'hB3);
    applyStimulus(8'h12, 8'hFF, 1'b1);
    expectBeat(8'hB3, 1'b1, 3'd1);
    @(negedge clk_i);
    checkOutput("lock_locked_b3", 32'(locked_o),    32'd1);
    checkOutput("lock_ready_b3",  32'(req_ready_o), 32'h02);
    nextCycle();
    applyStimulus(8'h10, 8'hFF, 1'b1);
    expectBeat(8'hC4, 1'b1, 3'd4);
    @(negedge clk_i);
    checkOutput("lock_released", 32'(locked_o),    32'd0);
    checkOutput("lock_ready_c4", 32'(req_ready_o), 32'h10);
    nextCycle();

    // Reset mid-packet: lock lane 2, reset, then lane 0 wins from ptr 0
    setLane(2, 8'hD2);
    applyStimulus(8'h04, 8'hFB, 1'b1);
    expectBeat(8'hD2, 1'b0, 3'd2);
    @(negedge clk_i);
    checkOutput("mid_ready_d2", 32'(req_ready_o), 32'h04);
    nextCycle();
    applyStimulus(8'h00, 8'hFB, 1'b1);
    @(negedge clk_i);
    checkOutput("mid_locked", 32'(locked_o), 32'd1);
    nextCycle();
    rst_i = 1'b1;
    applyStimulus(8'h05, 8'hFF, 1'b1);
    nextCycle();
    rst_i = 1'b0;
    expectBeat(8'h10, 1'b1, 3'd0);
    @(negedge clk_i);
    checkOutput("mid_rst_locked", 32'(locked_o),    32'd0);
    checkOutput("mid_rst_valid",  32'(out_valid_o), 32'd0);
    checkOutput("mid_rst_data",   32'(out_data_o),  32'd0);
    checkOutput("mid_rst_sel",    32'(sel_o),       32'd0);
    checkOutput("mid_rst_ready0", 32'(req_ready_o), 32'h01);
    nextCycle();
    applyStimulus(8'h04, 8'hFF, 1'b1);
    expectBeat(8'hD2, 1'b1, 3'd2);
    @(negedge clk_i);
    checkOutput("mid_rst_ready2", 32'(req_ready_o), 32'h04);
    nextCycle();
    applyStimulus(8'h00, 8'hFF, 1'b1);
    nextCycle();
    nextCycle();

    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
